ysyx_23060187_mdu: RTL and testbench

//   Iterative multiply/divide unit, the multi-cycle companion to the single-cycle ALU.

---
 rtl/ysyx_23060187_mdu_if.sv | 25 ++
 rtl/ysyx_23060187_mdu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_23060187_mdu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060187_mdu_if.sv
// Request/response handshake bundle between the EXU and the iterative multiply/divide unit.
interface ysyx_23060187_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] opnum1;
  logic [XLEN-1:0] opnum2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            div_by_zero;

  modport master (
    output in_valid, op, opnum1, opnum2, out_ready,
    input  in_ready, out_valid, result, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, opnum1, opnum2, out_ready,
    output in_ready, out_valid, result, zero, div_by_zero
  );
endinterface

// File: rtl/ysyx_23060187_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle on unsigned magnitudes with a final sign-fix cycle.
module ysyx_23060187_mdu #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ysyx_23060187_mdu_if.slave  bus
);
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              dbz_q, dbz_d;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              divZero, divOvf;
  logic [XLEN-1:0]   specResult;
  logic [XLEN-1:0]   mulAddend;
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift, divTrial;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix, remFix, fixResult;

  // MULH/DIV/REM treat both operands as signed, MULHSU only rs1.
  assign sgn1 = bus.opnum1[XLEN-1] &
                (bus.op == 3'b001 || bus.op == 3'b010 || bus.op == 3'b100 || bus.op == 3'b110);
  assign sgn2 = bus.opnum2[XLEN-1] &
                (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110);
  assign mag1 = sgn1 ? -bus.opnum1 : bus.opnum1;
  assign mag2 = sgn2 ? -bus.opnum2 : bus.opnum2;

  assign divZero    = bus.op[2] && (bus.opnum2 == '0);
  assign divOvf     = bus.op[2] && !bus.op[0] && (bus.opnum1 == MIN_NEG) && (bus.opnum2 == '1);
  assign specResult = divZero ? (bus.op[1] ? bus.opnum1 : '1) : (bus.op[1] ? '0 : MIN_NEG);

  assign mulAddend = acc_q[0] ? opb_q : '0;
  assign mulSum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mulAddend};
  assign divShift  = acc_q[2*XLEN-1:XLEN-1];
  assign divTrial  = divShift - {1'b0, opb_q};

  // Remainder follows the dividend's sign; quotient and product follow sign1^sign2.
  assign prodFix   = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
  assign quoFix    = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign remFix    = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fixResult = op_q[2] ? (op_q[1] ? remFix : quoFix)
                             : ((op_q == 3'b000) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          sign1_d = sgn1;
          sign2_d = sgn2;
          cnt_d   = '0;
          if (divZero || divOvf) begin
            result_d = specResult;
            zero_d   = (specResult == '0);
            dbz_d    = divZero;
            state_d  = S_DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = S_CALC;
            if (bus.op[2]) begin
              acc_d = {{XLEN{1'b0}}, mag1};
              opb_d = mag2;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag2};
              opb_d = mag1;
            end
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = divTrial[XLEN] ? {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {mulSum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        result_d = fixResult;
        zero_d   = (fixResult == '0);
        state_d  = S_DONE;
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      zero_d   = zero_q;
      dbz_d    = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.zero        = zero_q & bus.out_valid;
  assign bus.div_by_zero = dbz_q & bus.out_valid;
endmodule

// File: tb/tb_ysyx_23060187_mdu.sv
// Self-checking bench for the iterative MDU: directed RV32M vectors, handshake corner
// cases and random operations compared against a plain-arithmetic reference model.
module tb_ysyx_23060187_mdu;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ysyx_23060187_mdu_if #(.XLEN(XLEN)) bus ();

  ysyx_23060187_mdu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns right after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.opnum1   = a;
    bus.opnum2   = b;
    @(posedge clk);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 60);
  endtask

  task automatic releaseResult(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_release"}, {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [31:0] exp;
    string       tag;
    exp = refResult(op, a, b);
    tag = $sformatf("op%0d_%h_%h", op, a, b);
    applyStimulus(op, a, b);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(op, a, b)));
    checkOutput({tag, "_result"}, {32'b0, bus.result}, {32'b0, exp});
    checkOutput({tag, "_zero"}, {63'b0, bus.zero}, {63'b0, exp == 0});
    checkOutput({tag, "_dbz"}, {63'b0, bus.div_by_zero}, {63'b0, op[2] && b == 0});
    checkOutput({tag, "_inready"}, {63'b0, bus.in_ready}, 64'b0);
    releaseResult(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_inready"}, {63'b0, bus.in_ready}, 64'b1);
    checkOutput({tag, "_outvalid"}, {63'b0, bus.out_valid}, 64'b0);
    checkOutput({tag, "_result"}, {32'b0, bus.result}, 64'b0);
    checkOutput({tag, "_flags"}, {62'b0, bus.zero, bus.div_by_zero}, 64'b0);
  endtask

  initial begin
    int          lat;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'd0;
    bus.opnum1    = '0;
    bus.opnum2    = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    runOp(3'd0, 32'd7, 32'hFFFF_FFFD);
    runOp(3'd1, MIN_NEG, MIN_NEG);
    runOp(3'd2, MIN_NEG, MIN_NEG);
    runOp(3'd3, MIN_NEG, MIN_NEG);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2);
    runOp(3'd5, 32'd100, 32'd7);
    runOp(3'd7, 32'd100, 32'd7);
    runOp(3'd5, 32'd1234, 32'd0);
    runOp(3'd6, 32'd1234, 32'd0);
    runOp(3'd4, MIN_NEG, 32'hFFFF_FFFF);
    runOp(3'd6, MIN_NEG, 32'hFFFF_FFFF);

    // Back-pressure: result must hold while the consumer stalls.
    applyStimulus(3'd5, 32'd100, 32'd7);
    waitResult(lat);
    repeat (5) begin
      checkOutput("bp_hold", {30'b0, bus.result, bus.out_valid, bus.in_ready}, {30'b0, 32'd14, 1'b1, 1'b0});
      @(negedge clk);
    end
    releaseResult("bp");

    // Flush mid-calculation at counter 10.
    applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (11) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_calc", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
    runOp(3'd0, 32'h0001_0003, 32'h0002_0005);

    // Flush with a request in IDLE: the request must not be taken.
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'd5;
    bus.opnum1   = 32'd5;
    bus.opnum2   = 32'd0;
    @(posedge clk);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_idle", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);

    // Flush in DONE drops the pending result.
    applyStimulus(3'd5, 32'd5, 32'd0);
    waitResult(lat);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_done", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);

    // Reset mid-operation at counter 5.
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetState("midreset");
    rst_n = 1'b1;
    runOp(3'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    runOp(3'd7, 32'hFFFF_FFF0, 32'd3);

    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      runOp(rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
